// File: rtl/macro_op_expander.sv
// macro_op_expander
//   Sits between fetch and decode. A fused load-immediate macro-op (rd plus
//   a full 32-bit constant) is expanded into legal LUI/ADDI micro-ops, one per
//   cycle. Non-fused instructions pass through unchanged. The output is a
//   registered micro-op stage.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
//   valid && ready. A producer holding valid keeps its payload stable until
//   the transfer; ready may change freely.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous pipeline flush (highest priority)
//   in_valid/in_ready  upstream handshake
//   in_fused           1 = in_inst/in_imm form a fused load-immediate
//   in_inst            instruction; for fused ops only rd = in_inst[11:7]
//   in_imm             32-bit constant for fused ops
//   in_pc              PC of the (first) instruction
//   out_valid/out_ready downstream handshake
//   out_inst, out_pc   micro-op encoding and PC
//   out_last           1 = final micro-op of the accepted input
module macro_op_expander #(
   parameter bit          ENABLE_SHORT = 1'b1,
   parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_fused,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_imm,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        out_last
);

   // IDLE: output empty or holding a final micro-op.
   // SECOND: output holds the LUI, the ADDI waits in the pending register.
   typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        out_last_q, out_last_d;
   logic [31:0] pend_inst_q, pend_inst_d;
   logic [31:0] pend_pc_q, pend_pc_d;

   logic        accept;
   logic [4:0]  rd;
   logic [11:0] lo;
   logic [19:0] hi;
   logic [31:0] lui_op;
   logic [31:0] addi_x0_op;
   logic [31:0] addi_rd_op;

   // ADDI sign-extends its 12-bit immediate, so the upper part is bumped by
   // one whenever bit 11 is set; the 20-bit add wraps 0xFFFFF+1 to 0.
   assign rd         = in_inst[11:7];
   assign lo         = in_imm[11:0];
   assign hi         = in_imm[31:12] + {19'd0, in_imm[11]};
   assign lui_op     = {hi, rd, 7'b0110111};
   assign addi_x0_op = {lo, 5'd0, 3'b000, rd, 7'b0010011};
   assign addi_rd_op = {lo, rd, 3'b000, rd, 7'b0010011};

   assign in_ready = !flush && (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_pc_d    = out_pc_q;
      out_last_d  = out_last_q;
      pend_inst_d = pend_inst_q;
      pend_pc_d   = pend_pc_q;

      if (flush) begin
         out_valid_d = 1'b0;
         out_inst_d  = NOP_INST;
         pend_inst_d = NOP_INST;
         state_d     = IDLE;
      end else if (state_q == SECOND) begin
         if (out_ready) begin
            out_inst_d = pend_inst_q;
            out_pc_d   = pend_pc_q;
            out_last_d = 1'b1;
            state_d    = IDLE;
         end
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_pc_d    = in_pc;
         out_last_d  = 1'b1;
         if (!in_fused) begin
            out_inst_d = in_inst;
         end else if (rd == 5'd0) begin
            out_inst_d = NOP_INST;
         end else if (ENABLE_SHORT && (hi == 20'd0)) begin
            out_inst_d = addi_x0_op;
         end else if (ENABLE_SHORT && (lo == 12'd0)) begin
            out_inst_d = lui_op;
         end else begin
            out_inst_d  = lui_op;
            out_last_d  = 1'b0;
            pend_inst_d = addi_rd_op;
            pend_pc_d   = in_pc + 32'd4;
            state_d     = SECOND;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_inst_q  <= NOP_INST;
         out_pc_q    <= 32'd0;
         out_last_q  <= 1'b0;
         pend_inst_q <= NOP_INST;
         pend_pc_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_pc_q    <= out_pc_d;
         out_last_q  <= out_last_d;
         pend_inst_q <= pend_inst_d;
         pend_pc_q   <= pend_pc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_inst  = out_inst_q;
   assign out_pc    = out_pc_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_macro_op_expander.sv
module tb_macro_op_expander;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        in_fused;
   logic [31:0] in_inst;
   logic [31:0] in_imm;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_last;

   int errors = 0;
   int checks = 0;

   // Expected micro-op stream, each entry {inst, pc, last}; the front entry is
   // the one the output register should be presenting.
   logic [64:0] exp_q[$];

   logic        stall_prev = 1'b0;
   logic [31:0] prev_inst, prev_pc;
   logic        prev_last;

   macro_op_expander dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fused  (in_fused),
      .in_inst   (in_inst),
      .in_imm    (in_imm),
      .in_pc     (in_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_pc    (out_pc),
      .out_last  (out_last)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: what a single accepted input should turn into.
   // The upper part is derived as (imm + 0x800) >> 12, which is the rounding
   // that makes LUI + sign-extended ADDI reproduce the constant.
   function automatic void expand(input logic fused, input logic [31:0] inst,
                                  input logic [31:0] imm, input logic [31:0] pc);
      logic [31:0] rd, lo, hi, rounded, lui, addi_x0, addi_rd;
      if (!fused) begin
         exp_q.push_back({inst, pc, 1'b1});
         return;
      end
      rd      = (inst >> 7) & 32'h1F;
      lo      = imm & 32'hFFF;
      rounded = imm + 32'h800;
      hi      = rounded >> 12;
      lui     = (hi << 12) | (rd << 7) | 32'h37;
      addi_x0 = (lo << 20) | (rd << 7) | 32'h13;
      addi_rd = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
      if (rd == 0)
         exp_q.push_back({NOP, pc, 1'b1});
      else if (hi == 0)
         exp_q.push_back({addi_x0, pc, 1'b1});
      else if (lo == 0)
         exp_q.push_back({lui, pc, 1'b1});
      else begin
         exp_q.push_back({lui, pc, 1'b0});
         exp_q.push_back({addi_rd, pc + 32'd4, 1'b1});
      end
   endfunction

   // ---------------- driver ----------------
   // Called at posedge+1: drives one cycle of inputs, checks the DUT against
   // the model, updates the model, and advances to the next posedge+1.
   task automatic cycle(input logic v, input logic fu, input logic [31:0] inst,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      logic        exp_ready;
      logic [64:0] e;
      in_valid  = v;
      in_fused  = fu;
      in_inst   = inst;
      in_imm    = imm;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      #1;
      // Mid-expansion means the output holds a non-final micro-op.
      exp_ready = !fl && !(out_valid && !out_last) && (!out_valid || ordy);
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      if (stall_prev) begin
         check("hold_inst", out_inst, prev_inst);
         check("hold_pc", out_pc, prev_pc);
         check("hold_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (fl) begin
         exp_q.delete();
      end else begin
         if (out_valid && ordy && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_inst", out_inst, e[64:33]);
            check("out_pc", out_pc, e[32:1]);
            check("out_last", {31'd0, out_last}, {31'd0, e[0]});
         end
         if (v && exp_ready) expand(fu, inst, imm, pc);
      end
      stall_prev = out_valid && !ordy && !fl;
      prev_inst  = out_inst;
      prev_pc    = out_pc;
      prev_last  = out_last;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
   endtask

   task automatic check_reset_values();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_inst", out_inst, NOP);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_last", {31'd0, out_last}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r_inst, r_imm;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_fused  = 1'b0;
      in_inst   = 32'd0;
      in_imm    = 32'd0;
      in_pc     = 32'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Split 0x12345678 into rd=5: LUI then ADDI.
      cycle(1'b1, 1'b1, 32'h0000_0280, 32'h1234_5678, 32'h100, 1'b1, 1'b0);
      check("lit_lui", out_inst, 32'h1234_52B7);
      idle(1'b1);
      check("lit_addi", out_inst, 32'h6782_8293);
      idle(1'b1);

      // Sign correction: lo has bit 11 set.
      cycle(1'b1, 1'b1, 32'h0000_0280, 32'h1234_5FFF, 32'h200, 1'b1, 1'b0);
      check("lit_lui_sc", out_inst, 32'h1234_62B7);
      idle(1'b1);
      check("lit_addi_sc", out_inst, 32'hFFF2_8293);

      // Single-op collapses, back to back with no bubble.
      cycle(1'b1, 1'b1, 32'h0000_0500, 32'hFFFF_F800, 32'h300, 1'b1, 1'b0);
      check("lit_hi_wrap", out_inst, 32'h8000_0513);
      cycle(1'b1, 1'b1, 32'h0000_0500, 32'h0000_0123, 32'h304, 1'b1, 1'b0);
      check("lit_hi_zero", out_inst, 32'h1230_0513);
      cycle(1'b1, 1'b1, 32'h0000_0080, 32'hABCD_E000, 32'h308, 1'b1, 1'b0);
      check("lit_lo_zero", out_inst, 32'hABCD_E0B7);
      cycle(1'b1, 1'b1, 32'hFFFF_F07F, 32'h1234_5678, 32'h30C, 1'b1, 1'b0);
      check("lit_rd0", out_inst, NOP);
      idle(1'b1);

      // Backpressure on the LUI, then flush drops the ADDI.
      cycle(1'b1, 1'b1, 32'h0000_0280, 32'h1234_5678, 32'h400, 1'b1, 1'b0);
      repeat (3) idle(1'b0);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check("flush_out_inst", out_inst, NOP);
      idle(1'b1);
      cycle(1'b1, 1'b0, 32'h00A0_0093, 32'd0, 32'h500, 1'b1, 1'b0);
      check("lit_pass", out_inst, 32'h00A0_0093);
      idle(1'b1);

      // Reset in the middle of an expansion.
      cycle(1'b1, 1'b1, 32'h0000_0280, 32'h1234_5678, 32'h600, 1'b0, 1'b0);
      idle(1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_values();
      exp_q.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(1'b1);

      // Randomised traffic against the model.
      for (int i = 0; i < 800; i++) begin
         r_inst = $urandom;
         if ($urandom_range(0, 7) == 0) r_inst[11:7] = 5'd0;
         case ($urandom_range(0, 4))
            0:       r_imm = $urandom & 32'hFFFF_F000;
            1:       r_imm = $urandom_range(0, 32'h7FF);
            2:       r_imm = 32'hFFFF_F800 | $urandom_range(0, 32'h7FF);
            default: r_imm = $urandom;
         endcase
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, r_inst, r_imm,
               $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
      end
      // Drain whatever is still expected.
      for (int i = 0; i < 4; i++) idle(1'b1);
      check("drain_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
